// File: rtl/bisr_weight_load_controller_if.sv
// Handshake and data bundle between the BISR weight-load controller and its neighbours.
// master: the controller; slave: DMA / scheduler / allocation block / systolic consumer side.
interface bisr_weight_load_controller_if #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
);
    logic                                  map_load_req;
    logic                                  start;
    logic                                  src_valid;
    logic                                  src_ready;
    logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] src_data;
    logic                                  envm_wr_en;
    logic                                  weight_start;
    logic                                  weight_valid;
    logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] input_weights;
    logic                                  recovery_done;
    logic                                  recovery_success;
    logic                                  rd_ready;
    logic [ADDR_WIDTH-1:0]                 read_addr;
    logic                                  rd_valid;
    logic                                  rd_last;
    logic                                  busy;
    logic                                  tile_done;
    logic                                  fail;

    modport master (
        input  map_load_req, start, src_valid, src_data, recovery_done, recovery_success, rd_ready,
        output src_ready, envm_wr_en, weight_start, weight_valid, input_weights,
               read_addr, rd_valid, rd_last, busy, tile_done, fail
    );

    modport slave (
        output map_load_req, start, src_valid, src_data, recovery_done, recovery_success, rd_ready,
        input  src_ready, envm_wr_en, weight_start, weight_valid, input_weights,
               read_addr, rd_valid, rd_last, busy, tile_done, fail
    );
endinterface

// File: rtl/bisr_weight_load_controller.sv
// Per-tile sequencer: fault-map commit, allocation restart, row stream, recovery verdict, read sweep.
// Optional macro BISR_LOAD_TIMEOUT_EN adds a WAIT_DONE watchdog (TIMEOUT_CYCLES exists only then).
module bisr_weight_load_controller #(
    parameter int SYSTOLIC_SIZE  = 8,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int ADDR_WIDTH     = $clog2(SYSTOLIC_SIZE)
`ifdef BISR_LOAD_TIMEOUT_EN
    ,parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input logic                           clk,
    input logic                           rst_n,
    bisr_weight_load_controller_if.master bus
);
    localparam int                    BEAT_W    = $clog2(SYSTOLIC_SIZE) + 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(SYSTOLIC_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAP,
        S_WSTART,
        S_STREAM,
        S_WAIT_DONE,
        S_READ
    } state_t;

    state_t                state, state_nxt;
    logic [BEAT_W-1:0]     beat_cnt, beat_cnt_nxt;
    logic [ADDR_WIDTH-1:0] rd_cnt, rd_cnt_nxt;
    logic                  map_pending;
    logic                  fail_q, fail_nxt;
    logic                  tile_done_q, tile_done_nxt;
    logic                  timeout;

`ifdef BISR_LOAD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] wd_cnt;

    // Held at zero outside WAIT_DONE, so every entry starts a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    wd_cnt <= '0;
        else if (state != S_WAIT_DONE) wd_cnt <= '0;
        else                           wd_cnt <= wd_cnt + 1'b1;
    end

    assign timeout = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            beat_cnt    <= '0;
            rd_cnt      <= '0;
            map_pending <= 1'b1;
            fail_q      <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            beat_cnt    <= beat_cnt_nxt;
            rd_cnt      <= rd_cnt_nxt;
            fail_q      <= fail_nxt;
            tile_done_q <= tile_done_nxt;
            // A request landing in the commit cycle itself keeps the map pending for the next tile.
            map_pending <= bus.map_load_req | (map_pending & (state != S_MAP));
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        rd_cnt_nxt    = rd_cnt;
        fail_nxt      = fail_q;
        tile_done_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    fail_nxt  = 1'b0;
                    state_nxt = (map_pending | bus.map_load_req) ? S_MAP : S_WSTART;
                end
            end
            S_MAP:    state_nxt = S_WSTART;
            S_WSTART: begin
                beat_cnt_nxt = '0;
                state_nxt    = S_STREAM;
            end
            S_STREAM: begin
                // src_ready is high throughout STREAM, so src_valid alone marks an accepted beat.
                if (bus.src_valid) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (beat_cnt == LAST_BEAT) state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.recovery_done) begin
                    if (bus.recovery_success) begin
                        rd_cnt_nxt = '0;
                        state_nxt  = S_READ;
                    end else begin
                        fail_nxt      = 1'b1;
                        tile_done_nxt = 1'b1;
                        state_nxt     = S_IDLE;
                    end
                end else if (timeout) begin
                    fail_nxt      = 1'b1;
                    tile_done_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            S_READ: begin
                if (bus.rd_ready) begin
                    if (rd_cnt == LAST_ROW) begin
                        rd_cnt_nxt    = '0;
                        tile_done_nxt = 1'b1;
                        state_nxt     = S_IDLE;
                    end else begin
                        rd_cnt_nxt = rd_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.envm_wr_en    = (state == S_MAP);
    assign bus.weight_start  = (state == S_WSTART);
    assign bus.src_ready     = (state == S_STREAM);
    assign bus.weight_valid  = bus.src_valid & bus.src_ready;
    assign bus.input_weights = bus.src_ready ? bus.src_data : '0;
    assign bus.rd_valid      = (state == S_READ);
    assign bus.read_addr     = rd_cnt;
    assign bus.rd_last       = bus.rd_valid & (rd_cnt == LAST_ROW);
    assign bus.busy          = (state != S_IDLE);
    assign bus.tile_done     = tile_done_q;
    assign bus.fail          = fail_q;
endmodule
